// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared constants, fault codes and helpers for CPU memories
package cpu_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fault_code_e;

  // Number of byte-offset bits inside one memory word
  function automatic int wb_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Misalignment takes priority so a misaligned, out-of-range address reports misalign
  function automatic fault_code_e classify(input logic misaligned, input logic out_of_range);
    if (misaligned) begin
      return FAULT_MISALIGN;
    end else if (out_of_range) begin
      return FAULT_RANGE;
    end else begin
      return FAULT_NONE;
    end
  endfunction

endpackage

// File: rtl/mem_pipe_stage.sv
// rtl/mem_pipe_stage.sv - one valid/fault/data pipeline register with flush
module mem_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic         in_fault,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_fault,
  output logic [W-1:0] out_data
);

  // Advance every cycle; a flush kills whatever is entering this stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_fault <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid && !flush;
      out_fault <= in_fault && in_valid && !flush;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/inst_mem_pipe.sv
// rtl/inst_mem_pipe.sv - parametrised instruction memory with fetch pipeline and loader port
module inst_mem_pipe
  import cpu_mem_pkg::*;
#(
  parameter int    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int    DEPTH_WORDS  = 4096,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  input  logic                  fetch_flush,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_fault,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int WB     = wb_bits(DATA_WIDTH);
  localparam int IDX_W  = ADDR_WIDTH - WB;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  reg [DATA_WIDTH-1:0] mem [0:DEPTH_WORDS-1];

  logic [IDX_W-1:0]      fetch_idx;
  logic [IDX_W-1:0]      load_idx;
  fault_code_e           fetch_code;
  fault_code_e           load_code;
  logic                  accept;
  logic                  load_ok;
  logic                  s0_valid;
  logic                  s0_fault;
  logic [MEM_AW-1:0]     s0_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Loads own the cycle, so fetch and write never meet on the array
  assign fetch_ready = !load_en;
  assign accept      = fetch_req && fetch_ready;

  assign fetch_idx  = fetch_addr[ADDR_WIDTH-1:WB];
  assign load_idx   = load_addr[ADDR_WIDTH-1:WB];
  assign fetch_code = classify(|fetch_addr[WB-1:0], 32'(fetch_idx) >= DEPTH_WORDS);
  assign load_code  = classify(|load_addr[WB-1:0], 32'(load_idx) >= DEPTH_WORDS);
  assign load_ok    = load_en && (load_code == FAULT_NONE);

  // Single write port; bad loader addresses are dropped without a write
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx[MEM_AW-1:0]] <= load_data;
    end
  end

  // Address stage: a request accepted alongside a flush is post-redirect and survives
  mem_pipe_stage #(.W(MEM_AW)) u_stage0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (fetch_flush && !accept),
    .in_valid  (accept),
    .in_fault  (fetch_code != FAULT_NONE),
    .in_data   (fetch_idx[MEM_AW-1:0]),
    .out_valid (s0_valid),
    .out_fault (s0_fault),
    .out_data  (s0_idx)
  );

  // Faulted or idle slots never touch the array and present zero data
  assign rd_word = (s0_valid && !s0_fault) ? mem[s0_idx] : '0;

  if (READ_LATENCY == 2) begin : g_lat2
    // Output data register; pre-flush contents of the address stage die here
    mem_pipe_stage #(.W(DATA_WIDTH)) u_stage1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (fetch_flush),
      .in_valid  (s0_valid),
      .in_fault  (s0_fault),
      .in_data   (rd_word),
      .out_valid (fetch_valid),
      .out_fault (fetch_fault),
      .out_data  (fetch_data)
    );
  end else begin : g_lat1
    assign fetch_valid = s0_valid;
    assign fetch_fault = s0_fault;
    assign fetch_data  = rd_word;
  end

endmodule
